// File: rtl/cpu_pkg.sv
// Shared opcode/funct constants, ALU encoding and the ID/EX record layout for the MIPS pipeline.
package cpu_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnSll = 6'h00;
  localparam logic [5:0] FnSrl = 6'h02;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOr  = 3'd3,
    AluSlt = 3'd4,
    AluSll = 3'd5,
    AluSrl = 3'd6,
    AluLui = 3'd7
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    mem_to_reg;
    logic    branch_eq;
    logic    branch_ne;
    logic    jump;
  } ctrl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    ctrl_t       ctrl;
    logic        illegal;
  } idex_t;

  function automatic logic [31:0] sext16(logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch, register-file, writeback and ID/EX signal bundle around the decode stage.
interface decode_stage_if;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        id_stall;
  logic [4:0]  rf_read_reg1;
  logic [4:0]  rf_read_reg2;
  logic [31:0] rf_read_data1;
  logic [31:0] rf_read_data2;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_shamt;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_dest;
  logic [2:0]  ex_alu_op;
  logic        ex_alu_src;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic        ex_branch_eq;
  logic        ex_branch_ne;
  logic        ex_jump;
  logic        ex_illegal;

  modport slave (
    input  if_valid, if_instr, if_pc, flush, rf_read_data1, rf_read_data2,
           wb_en, wb_reg, wb_data,
    output id_stall, rf_read_reg1, rf_read_reg2, ex_valid, ex_pc, ex_rs_data, ex_rt_data,
           ex_imm, ex_shamt, ex_rs, ex_rt, ex_dest, ex_alu_op, ex_alu_src, ex_mem_read,
           ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch_eq, ex_branch_ne, ex_jump,
           ex_illegal
  );

  modport master (
    output if_valid, if_instr, if_pc, flush, rf_read_data1, rf_read_data2,
           wb_en, wb_reg, wb_data,
    input  id_stall, rf_read_reg1, rf_read_reg2, ex_valid, ex_pc, ex_rs_data, ex_rt_data,
           ex_imm, ex_shamt, ex_rs, ex_rt, ex_dest, ex_alu_op, ex_alu_src, ex_mem_read,
           ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch_eq, ex_branch_ne, ex_jump,
           ex_illegal
  );
endinterface

// File: rtl/instr_decoder.sv
// Combinational MIPS decoder: control bits, immediate, destination, source-use flags, illegal.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [3:0]  pc_hi_i,
  output ctrl_t       ctrl_o,
  output logic [31:0] imm_o,
  output logic [4:0]  dest_o,
  output logic        use_rs_o,
  output logic        use_rt_o,
  output logic        illegal_o
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [15:0] imm16;
  logic        wr_rd;
  logic        wr_rt;

  assign op    = instr_i[31:26];
  assign fn    = instr_i[5:0];
  assign imm16 = instr_i[15:0];

  always_comb begin
    ctrl_o    = '0;
    imm_o     = '0;
    dest_o    = '0;
    use_rs_o  = 1'b0;
    use_rt_o  = 1'b0;
    illegal_o = 1'b0;
    wr_rd     = 1'b0;
    wr_rt     = 1'b0;

    case (op)
      OpRtype: begin
        wr_rd    = 1'b1;
        use_rs_o = 1'b1;
        use_rt_o = 1'b1;
        case (fn)
          FnSll: begin ctrl_o.alu_op = AluSll; use_rs_o = 1'b0; end
          FnSrl: begin ctrl_o.alu_op = AluSrl; use_rs_o = 1'b0; end
          FnAdd: ctrl_o.alu_op = AluAdd;
          FnSub: ctrl_o.alu_op = AluSub;
          FnAnd: ctrl_o.alu_op = AluAnd;
          FnOr:  ctrl_o.alu_op = AluOr;
          FnSlt: ctrl_o.alu_op = AluSlt;
          default: illegal_o = 1'b1;
        endcase
      end
      OpAddi: begin
        ctrl_o.alu_src = 1'b1;
        imm_o          = sext16(imm16);
        use_rs_o       = 1'b1;
        wr_rt          = 1'b1;
      end
      OpLw: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        imm_o             = sext16(imm16);
        use_rs_o          = 1'b1;
        wr_rt             = 1'b1;
      end
      OpSw: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        imm_o            = sext16(imm16);
        use_rs_o         = 1'b1;
        use_rt_o         = 1'b1;
      end
      OpBeq, OpBne: begin
        ctrl_o.alu_op    = AluSub;
        ctrl_o.branch_eq = (op == OpBeq);
        ctrl_o.branch_ne = (op == OpBne);
        imm_o            = sext16(imm16);
        use_rs_o         = 1'b1;
        use_rt_o         = 1'b1;
      end
      OpAndi, OpOri: begin
        ctrl_o.alu_op  = (op == OpAndi) ? AluAnd : AluOr;
        ctrl_o.alu_src = 1'b1;
        imm_o          = {16'h0000, imm16};
        use_rs_o       = 1'b1;
        wr_rt          = 1'b1;
      end
      OpLui: begin
        ctrl_o.alu_op  = AluLui;
        ctrl_o.alu_src = 1'b1;
        imm_o          = {imm16, 16'h0000};
        wr_rt          = 1'b1;
      end
      OpJ: begin
        ctrl_o.jump = 1'b1;
        imm_o       = {pc_hi_i, instr_i[25:0], 2'b00};
      end
      default: illegal_o = 1'b1;
    endcase

    if (wr_rd) begin
      dest_o = instr_i[15:11];
    end else if (wr_rt) begin
      dest_o = instr_i[20:16];
    end
    // $0 is hardwired, so a write to it is simply not a write.
    ctrl_o.reg_write = (dest_o != 5'd0);

    if (illegal_o) begin
      ctrl_o   = '0;
      imm_o    = '0;
      dest_o   = '0;
      use_rs_o = 1'b0;
      use_rt_o = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: register-file addressing, load-use stall, flush and the ID/EX register.
// Optional same-cycle writeback bypass into the operands is enabled by defining WB_BYPASS_EN.
module decode_stage
  import cpu_pkg::*;
(
  input logic            clk,
  input logic            rst,
  decode_stage_if.slave  bus
);

  logic [4:0]  rs;
  logic [4:0]  rt;
  ctrl_t       dec_ctrl;
  logic [31:0] dec_imm;
  logic [4:0]  dec_dest;
  logic        dec_use_rs;
  logic        dec_use_rt;
  logic        dec_illegal;
  logic        hazard;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  idex_t       idex_d;
  idex_t       idex_q;

  assign rs = bus.if_instr[25:21];
  assign rt = bus.if_instr[20:16];

  instr_decoder u_decoder (
    .instr_i   (bus.if_instr),
    .pc_hi_i   (bus.if_pc[31:28]),
    .ctrl_o    (dec_ctrl),
    .imm_o     (dec_imm),
    .dest_o    (dec_dest),
    .use_rs_o  (dec_use_rs),
    .use_rt_o  (dec_use_rt),
    .illegal_o (dec_illegal)
  );

  // Load in EX whose result a source of this instruction needs: hold one cycle.
  always_comb begin
    hazard = bus.if_valid & idex_q.valid & idex_q.ctrl.mem_read & (idex_q.dest != 5'd0) &
             ((dec_use_rs & (rs == idex_q.dest)) | (dec_use_rt & (rt == idex_q.dest)));
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    rs_data = bus.rf_read_data1;
    rt_data = bus.rf_read_data2;
    if (bus.wb_en && (bus.wb_reg != 5'd0) && (bus.wb_reg == rs)) rs_data = bus.wb_data;
    if (bus.wb_en && (bus.wb_reg != 5'd0) && (bus.wb_reg == rt)) rt_data = bus.wb_data;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{bus.wb_en, bus.wb_reg, bus.wb_data};
  assign rs_data   = bus.rf_read_data1;
  assign rt_data   = bus.rf_read_data2;
`endif

  always_comb begin
    idex_d = '0;
    if (!bus.flush && bus.if_valid && !hazard) begin
      if (dec_illegal) begin
        idex_d.illegal = 1'b1;
      end else begin
        idex_d.valid   = 1'b1;
        idex_d.pc      = bus.if_pc;
        idex_d.rs_data = rs_data;
        idex_d.rt_data = rt_data;
        idex_d.imm     = dec_imm;
        idex_d.shamt   = bus.if_instr[10:6];
        idex_d.rs      = rs;
        idex_d.rt      = rt;
        idex_d.dest    = dec_dest;
        idex_d.ctrl    = dec_ctrl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign bus.id_stall      = hazard & ~bus.flush & ~rst;
  assign bus.rf_read_reg1  = rs;
  assign bus.rf_read_reg2  = rt;
  assign bus.ex_valid      = idex_q.valid;
  assign bus.ex_pc         = idex_q.pc;
  assign bus.ex_rs_data    = idex_q.rs_data;
  assign bus.ex_rt_data    = idex_q.rt_data;
  assign bus.ex_imm        = idex_q.imm;
  assign bus.ex_shamt      = idex_q.shamt;
  assign bus.ex_rs         = idex_q.rs;
  assign bus.ex_rt         = idex_q.rt;
  assign bus.ex_dest       = idex_q.dest;
  assign bus.ex_alu_op     = idex_q.ctrl.alu_op;
  assign bus.ex_alu_src    = idex_q.ctrl.alu_src;
  assign bus.ex_mem_read   = idex_q.ctrl.mem_read;
  assign bus.ex_mem_write  = idex_q.ctrl.mem_write;
  assign bus.ex_reg_write  = idex_q.ctrl.reg_write;
  assign bus.ex_mem_to_reg = idex_q.ctrl.mem_to_reg;
  assign bus.ex_branch_eq  = idex_q.ctrl.branch_eq;
  assign bus.ex_branch_ne  = idex_q.ctrl.branch_ne;
  assign bus.ex_jump       = idex_q.ctrl.jump;
  assign bus.ex_illegal    = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: mnemonic-level reference model, per-cycle compare, directed + random.
module tb_decode_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [2:0]  alu;
    logic        alu_src;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        m2r;
    logic        beq;
    logic        bne;
    logic        jmp;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t e = '0;

  decode_stage_if bus ();

  decode_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  bit [5:0] ops [14] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h23, 6'h2B, 6'h04, 6'h05,
                         6'h0C, 6'h0D, 6'h0F, 6'h02, 6'h3F};
  bit [5:0] fns [8]  = '{6'h00, 6'h02, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, want %h", nm, $time, got, want);
    end
  endtask

  // Which source registers an instruction reads: bit0 = rs, bit1 = rt.
  function automatic bit [1:0] reads(logic [31:0] ins);
    case (ins[31:26])
      6'h00:   case (ins[5:0])
                 6'h00, 6'h02:                            return 2'b10;
                 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A:       return 2'b11;
                 default:                                 return 2'b00;
               endcase
      6'h04, 6'h05, 6'h2B:                                return 2'b11;
      6'h08, 6'h23, 6'h0C, 6'h0D:                         return 2'b01;
      default:                                            return 2'b00;
    endcase
  endfunction

  function automatic exp_t ref_decode(logic [31:0] ins, logic [31:0] pc, logic [31:0] d1,
                                      logic [31:0] d2);
    exp_t x = '0;
    bit ok = 1'b1;
    bit to_rd = 1'b0;
    bit to_rt = 1'b0;
    logic [31:0] se = {{16{ins[15]}}, ins[15:0]};
    case (ins[31:26])
      6'h00: begin
        to_rd = 1'b1;
        case (ins[5:0])
          6'h00: x.alu = 3'd5;
          6'h02: x.alu = 3'd6;
          6'h20: x.alu = 3'd0;
          6'h22: x.alu = 3'd1;
          6'h24: x.alu = 3'd2;
          6'h25: x.alu = 3'd3;
          6'h2A: x.alu = 3'd4;
          default: ok = 1'b0;
        endcase
      end
      6'h08: begin x.alu_src = 1; x.imm = se; to_rt = 1; end
      6'h23: begin x.alu_src = 1; x.imm = se; x.mr = 1; x.m2r = 1; to_rt = 1; end
      6'h2B: begin x.alu_src = 1; x.imm = se; x.mw = 1; end
      6'h04: begin x.alu = 3'd1; x.imm = se; x.beq = 1; end
      6'h05: begin x.alu = 3'd1; x.imm = se; x.bne = 1; end
      6'h0C: begin x.alu = 3'd2; x.alu_src = 1; x.imm = {16'h0, ins[15:0]}; to_rt = 1; end
      6'h0D: begin x.alu = 3'd3; x.alu_src = 1; x.imm = {16'h0, ins[15:0]}; to_rt = 1; end
      6'h0F: begin x.alu = 3'd7; x.alu_src = 1; x.imm = {ins[15:0], 16'h0}; to_rt = 1; end
      6'h02: begin x.jmp = 1; x.imm = {pc[31:28], ins[25:0], 2'b00}; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      x = '0;
      x.ill = 1'b1;
      return x;
    end
    x.valid = 1'b1;
    x.pc    = pc;
    x.rs    = ins[25:21];
    x.rt    = ins[20:16];
    x.shamt = ins[10:6];
    x.dest  = to_rd ? ins[15:11] : (to_rt ? ins[20:16] : 5'd0);
    x.rw    = (x.dest != 0);
    x.rsd   = d1;
    x.rtd   = d2;
`ifdef WB_BYPASS_EN
    if (bus.wb_en && bus.wb_reg != 0 && bus.wb_reg == x.rs) x.rsd = bus.wb_data;
    if (bus.wb_en && bus.wb_reg != 0 && bus.wb_reg == x.rt) x.rtd = bus.wb_data;
`endif
    return x;
  endfunction

  function automatic bit model_stall();
    bit [1:0] r = reads(bus.if_instr);
    if (rst || bus.flush || !bus.if_valid) return 1'b0;
    if (!(e.valid && e.mr && e.dest != 0)) return 1'b0;
    return (r[0] && bus.if_instr[25:21] == e.dest) || (r[1] && bus.if_instr[20:16] == e.dest);
  endfunction

  // Reference ID/EX contents, advanced at every capture edge.
  always @(posedge clk) begin : model
    exp_t nx;
    if (rst || bus.flush || !bus.if_valid || model_stall()) nx = '0;
    else nx = ref_decode(bus.if_instr, bus.if_pc, bus.rf_read_data1, bus.rf_read_data2);
    e = nx;
  end

  always @(negedge clk) begin : compare
    exp_t g;
    g = {bus.ex_valid, bus.ex_pc, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm, bus.ex_shamt,
         bus.ex_rs, bus.ex_rt, bus.ex_dest, bus.ex_alu_op, bus.ex_alu_src, bus.ex_mem_read,
         bus.ex_mem_write, bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_branch_eq,
         bus.ex_branch_ne, bus.ex_jump, bus.ex_illegal};
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL idex @%0t: got %h, want %h", $time, g, e);
    end
    chk("id_stall", {31'b0, bus.id_stall}, {31'b0, model_stall()});
    chk("rf_read_reg1", {27'b0, bus.rf_read_reg1}, {27'b0, bus.if_instr[25:21]});
    chk("rf_read_reg2", {27'b0, bus.rf_read_reg2}, {27'b0, bus.if_instr[20:16]});
  end

  task automatic drive(logic [31:0] ins, logic [31:0] d1, logic [31:0] d2);
    bus.if_instr      = ins;
    bus.if_valid      = 1'b1;
    bus.if_pc         = bus.if_pc + 32'd4;
    bus.rf_read_data1 = d1;
    bus.rf_read_data2 = d2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    bit [5:0] op = ops[$urandom_range(0, 13)];
    logic [31:0] ins;
    ins[31:26] = op;
    ins[25:21] = 5'($urandom_range(0, 7));
    ins[20:16] = 5'($urandom_range(0, 7));
    if (op == 6'h00) begin
      ins[15:11] = 5'($urandom_range(0, 7));
      ins[10:6]  = 5'($urandom);
      ins[5:0]   = fns[$urandom_range(0, 7)];
    end else begin
      ins[15:0] = 16'($urandom);
    end
    return ins;
  endfunction

  initial begin
    bit held;
    bus.if_valid = 1'b1;
    bus.if_instr = 32'h00221820;
    bus.if_pc    = 32'h0000_1000;
    bus.flush    = 1'b0;
    bus.rf_read_data1 = 32'd5;
    bus.rf_read_data2 = 32'd7;
    bus.wb_en   = 1'b0;
    bus.wb_reg  = 5'd0;
    bus.wb_data = 32'd0;

    // Reset held two cycles with a live instruction presented.
    tick();
    tick();
    chk("rst ex_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("rst ex_reg_write", {31'b0, bus.ex_reg_write}, 32'd0);
    chk("rst ex_dest", {27'b0, bus.ex_dest}, 32'd0);
    chk("rst id_stall", {31'b0, bus.id_stall}, 32'd0);
    rst = 1'b0;

    drive(32'h00221820, 32'd5, 32'd7);
    tick();
    chk("add rs_data", bus.ex_rs_data, 32'd5);
    chk("add rt_data", bus.ex_rt_data, 32'd7);
    chk("add dest", {27'b0, bus.ex_dest}, 32'd3);
    chk("add alu_op", {29'b0, bus.ex_alu_op}, 32'd0);
    chk("add reg_write", {31'b0, bus.ex_reg_write}, 32'd1);

    drive(32'h2004FFFF, 32'd0, 32'd0);
    tick();
    chk("addi imm", bus.ex_imm, 32'hFFFF_FFFF);
    chk("addi alu_src", {31'b0, bus.ex_alu_src}, 32'd1);

    drive(32'h3404FFFF, 32'd0, 32'd0);
    tick();
    chk("ori imm", bus.ex_imm, 32'h0000_FFFF);

    drive(32'h3C04FFFF, 32'd0, 32'd0);
    tick();
    chk("lui imm", bus.ex_imm, 32'hFFFF_0000);
    chk("lui alu_op", {29'b0, bus.ex_alu_op}, 32'd7);

    drive(32'h20200005, 32'd1, 32'd2);  // addi $0,$1,5
    tick();
    chk("addi $0 reg_write", {31'b0, bus.ex_reg_write}, 32'd0);

    drive(32'h08100000, 32'd0, 32'd0);
    bus.if_pc = 32'hA000_0004;
    tick();
    chk("j imm", bus.ex_imm, 32'hA040_0000);
    chk("j jump", {31'b0, bus.ex_jump}, 32'd1);

    // Load-use: one-cycle stall, then the add decodes.
    drive(32'h8C250000, 32'd0, 32'd0);
    tick();
    drive(32'h00A23020, 32'd9, 32'd2);
    #1 chk("loaduse stall", {31'b0, bus.id_stall}, 32'd1);
    tick();
    chk("loaduse bubble", {31'b0, bus.ex_valid}, 32'd0);
    chk("loaduse stall gone", {31'b0, bus.id_stall}, 32'd0);
    tick();
    chk("loaduse add valid", {31'b0, bus.ex_valid}, 32'd1);
    chk("loaduse add dest", {27'b0, bus.ex_dest}, 32'd6);

    drive(32'h8C250000, 32'd0, 32'd0);
    tick();
    drive(32'h00E23020, 32'd3, 32'd2);
    #1 chk("indep no stall", {31'b0, bus.id_stall}, 32'd0);
    tick();
    chk("indep valid", {31'b0, bus.ex_valid}, 32'd1);

    // Flush wins over a pending stall.
    drive(32'h8C250000, 32'd0, 32'd0);
    tick();
    drive(32'h00A23020, 32'd9, 32'd2);
    bus.flush = 1'b1;
    #1 chk("flush stall", {31'b0, bus.id_stall}, 32'd0);
    tick();
    chk("flush bubble", {31'b0, bus.ex_valid}, 32'd0);
    bus.flush = 1'b0;
    drive(32'h00221820, 32'd5, 32'd7);
    tick();
    chk("post flush dest", {27'b0, bus.ex_dest}, 32'd3);

    drive(32'hFC000000, 32'd0, 32'd0);
    tick();
    chk("illegal valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("illegal flag", {31'b0, bus.ex_illegal}, 32'd1);
    drive(32'h00221820, 32'd5, 32'd7);
    tick();
    chk("illegal one cycle", {31'b0, bus.ex_illegal}, 32'd0);

    // Same-cycle writeback of $1.
    drive(32'h00221820, 32'd0, 32'd7);
    bus.wb_en = 1'b1;
    bus.wb_reg = 5'd1;
    bus.wb_data = 32'h0000_ABCD;
    tick();
`ifdef WB_BYPASS_EN
    chk("bypass rs_data", bus.ex_rs_data, 32'h0000_ABCD);
`else
    chk("bypass rs_data", bus.ex_rs_data, 32'd0);
`endif
    drive(32'h00021820, 32'h11, 32'd7);
    bus.wb_reg = 5'd0;
    tick();
    chk("bypass $0", bus.ex_rs_data, 32'h11);
    bus.wb_en = 1'b0;

    // Reset during a stall drops the held instruction.
    drive(32'h8C250000, 32'd0, 32'd0);
    tick();
    drive(32'h00A23020, 32'd9, 32'd2);
    rst = 1'b1;
    tick();
    chk("rst mid-stall valid", {31'b0, bus.ex_valid}, 32'd0);
    rst = 1'b0;
    bus.if_valid = 1'b0;
    tick();
    chk("after rst idle", {31'b0, bus.ex_valid}, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      held = model_stall();
      tick();
      rst       = ($urandom_range(0, 59) == 0);
      bus.flush = ($urandom_range(0, 11) == 0);
      if (!held) begin
        bus.if_instr = rand_instr();
        bus.if_pc    = $urandom;
        bus.if_valid = ($urandom_range(0, 7) != 0);
      end
      bus.rf_read_data1 = $urandom;
      bus.rf_read_data2 = $urandom;
      bus.wb_en   = 1'($urandom);
      bus.wb_reg  = 5'($urandom_range(0, 7));
      bus.wb_data = $urandom;
    end
    tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
